// File: rtl/ac3_quant_out.sv
// Output stage of the AC3 accumulator: captures four lanes, quantizes each to Pa bits
// (shift, round-half-up, optional ReLU, saturate) and streams them over valid/ready.
module ac3_quant_out #(
    parameter int M   = 16,
    parameter int Pa  = 8,
    parameter int Pw  = 4,
    parameter int MNO = 288,
    parameter int SHW = 5,
    parameter int AW  = $clog2(M) + Pa + Pw + $clog2(MNO)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic signed [AW-1:0] in_0,
    input  logic signed [AW-1:0] in_1,
    input  logic signed [AW-1:0] in_2,
    input  logic signed [AW-1:0] in_3,
    input  logic [SHW-1:0]       shamt,
    input  logic                 relu_en,
    output logic signed [Pa-1:0] out_data,
    output logic [1:0]           out_lane,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 acc_clr,
    output logic                 busy,
    output logic                 done,
    output logic                 sat_flag
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SEND} state_t;

    localparam logic signed [AW:0] QMAX = (AW+1)'((2 ** (Pa-1)) - 1);
    localparam logic signed [AW:0] QMIN = (AW+1)'(-(2 ** (Pa-1)));

    state_t                r_state;
    state_t                w_next;
    logic signed [AW-1:0]  r_x [4];
    logic [SHW-1:0]        r_shamt;
    logic                  r_relu;
    logic [1:0]            r_lane;
    logic signed [Pa-1:0]  r_data;
    logic                  r_done;
    logic                  r_sat;
    logic signed [AW:0]    w_r;
    logic                  w_clip;
    logic signed [Pa-1:0]  w_q;

    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic signed [AW:0] round_shift(input logic signed [AW-1:0] x,
                                                       input logic [SHW-1:0]       sh);
        int                 s;
        logic signed [AW:0] rnd;
        s   = (int'(sh) > AW-1) ? AW-1 : int'(sh);
        rnd = (s == 0) ? '0 : ((AW+1)'(1) <<< (s - 1));
        return ((AW+1)'(x) + rnd) >>> s;
    endfunction

    function automatic logic signed [Pa-1:0] saturate(input logic signed [AW:0] v);
        if (v > QMAX)      return Pa'(QMAX);
        else if (v < QMIN) return Pa'(QMIN);
        else               return Pa'(v);
    endfunction

    always_comb begin
        w_r = round_shift(r_x[r_lane], r_shamt);
        if (r_relu && w_r[AW]) w_r = '0;
        w_clip = (w_r > QMAX) || (w_r < QMIN);
        w_q    = saturate(w_r);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (load) w_next = S_CALC;
            S_CALC:  w_next = S_SEND;
            S_SEND:  if (out_ready) w_next = (r_lane == 2'd3) ? S_IDLE : S_CALC;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= '{default: '0};
            r_shamt <= '0;
            r_relu  <= 1'b0;
            r_lane  <= 2'd0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: if (load) begin
                    r_x[0]  <= in_0;
                    r_x[1]  <= in_1;
                    r_x[2]  <= in_2;
                    r_x[3]  <= in_3;
                    r_shamt <= shamt;
                    r_relu  <= relu_en;
                    r_lane  <= 2'd0;
                    r_sat   <= 1'b0;
                end
                S_CALC: begin
                    r_data <= w_q;
                    if (w_clip) r_sat <= 1'b1;
                end
                S_SEND: if (out_ready) begin
                    if (r_lane == 2'd3) r_done <= 1'b1;
                    else                r_lane <= r_lane + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Lane 0 is only ever in CALC once per batch, so this is a single pulse.
    assign acc_clr   = (r_state == S_CALC) && (r_lane == 2'd0);
    assign out_valid = (r_state == S_SEND);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_data;
    assign out_lane  = r_lane;
    assign done      = r_done;
    assign sat_flag  = r_sat;

endmodule
